// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared ASCII constants and FSM state encoding for the hex dumper
//
// Purpose : constants and types shared by hex_ascii and uart_hex_dump.
// Ports   : none (package).
package uart_pkg;

   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_UA = 8'h41;
   localparam logic [7:0] ASCII_LA = 8'h61;

   typedef enum logic [3:0] {
      IDLE,
      RD_REQ,
      RD_CAP,
      HI,
      LO,
      SEP,
      CR,
      LF,
      GAP
   } state_t;

endpackage

// File: rtl/uart_hex_dump_if.sv
// rtl/uart_hex_dump_if.sv - RX/TX FIFO handshake bundle for the hex dumper
//
// Purpose : groups the RX FIFO read side and TX FIFO write side.
// Ports   : master = dump block (drives rx_rden, tx_wdata, tx_wten);
//           slave  = FIFO side (drives read data and all FIFO status).
interface uart_hex_dump_if;

   logic       rx_rden;
   logic [7:0] rx_rdata;
   logic       rx_fifo_dvalid;
   logic       rx_fifo_full;
   logic       rx_fifo_overrun;
   logic       rx_fifo_underrun;
   logic [7:0] tx_wdata;
   logic       tx_wten;
   logic       tx_fifo_full;
   logic       tx_fifo_overrun;
   logic       tx_fifo_underrun;

   modport master (
      output rx_rden, tx_wdata, tx_wten,
      input  rx_rdata, rx_fifo_dvalid, rx_fifo_full, rx_fifo_overrun, rx_fifo_underrun,
      input  tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun
   );

   modport slave (
      input  rx_rden, tx_wdata, tx_wten,
      output rx_rdata, rx_fifo_dvalid, rx_fifo_full, rx_fifo_overrun, rx_fifo_underrun,
      output tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun
   );

endinterface

// File: rtl/hex_ascii.sv
// rtl/hex_ascii.sv - combinational nibble to ASCII hex digit converter
//
// Purpose : maps 0-9 to '0'-'9' and 10-15 to 'A'-'F' or 'a'-'f'.
// Ports   : nibble[3:0] in, upper in (1 = uppercase), ascii[7:0] out.
module hex_ascii
   import uart_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       upper,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = ASCII_0 + {4'h0, nibble};
      if (nibble > 4'd9) begin
         ascii = (upper ? ASCII_UA : ASCII_LA) + {4'h0, nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/uart_hex_dump.sv
// rtl/uart_hex_dump.sv - streams RX FIFO bytes to the TX FIFO as ASCII hex lines
//
// Purpose : reads one byte at a time, writes "HH " per byte, ends a line with
//           CR LF after BYTES_PER_LINE bytes or after IDLE_FLUSH idle cycles.
// Ports   : clk, rst_n (sync, active-low); bus (uart_hex_dump_if.master) with
//           RX read strobe/data/status and TX write strobe/data/status;
//           dump_err sticky FIFO overrun/underrun flag.
module uart_hex_dump
   import uart_pkg::*;
#(
   parameter int          BYTES_PER_LINE = 16,
   parameter logic [23:0] IDLE_FLUSH     = 24'd2_000_000,
   parameter bit          UPPER_HEX      = 1'b1
)(
   input  logic            clk,
   input  logic            rst_n,
   uart_hex_dump_if.master bus,
   output logic            dump_err
);

   localparam int               CNT_W    = $clog2(BYTES_PER_LINE);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_LINE - 1);

   state_t           state, state_nx;
   state_t           ret_state, ret_nx;
   logic [CNT_W-1:0] byte_cnt, byte_cnt_nx;
   logic [23:0]      idle_cnt, idle_cnt_nx;
   logic [7:0]       byte_reg, byte_reg_nx;
   logic             rx_rden_nx;
   logic             tx_wten_nx;
   logic [7:0]       tx_wdata_nx;
   logic [7:0]       hi_ascii, lo_ascii;
   logic             rx_avail;

   hex_ascii u_hi (.nibble(byte_reg[7:4]), .upper(UPPER_HEX), .ascii(hi_ascii));
   hex_ascii u_lo (.nibble(byte_reg[3:0]), .upper(UPPER_HEX), .ascii(lo_ascii));

   // A full RX FIFO is by definition not empty.
   assign rx_avail = bus.rx_fifo_dvalid | bus.rx_fifo_full;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      ret_nx      = ret_state;
      byte_cnt_nx = byte_cnt;
      idle_cnt_nx = idle_cnt;
      byte_reg_nx = byte_reg;
      rx_rden_nx  = 1'b0;
      tx_wten_nx  = 1'b0;
      tx_wdata_nx = bus.tx_wdata;
      case (state)
         IDLE: begin
            // A pending byte wins over an expiring flush timer.
            if (rx_avail) begin
               rx_rden_nx  = 1'b1;
               idle_cnt_nx = '0;
               state_nx    = RD_REQ;
            end else if (byte_cnt != '0) begin
               if (idle_cnt == IDLE_FLUSH) begin
                  byte_cnt_nx = '0;
                  idle_cnt_nx = '0;
                  state_nx    = CR;
               end else begin
                  idle_cnt_nx = idle_cnt + 24'd1;
               end
            end
         end
         RD_REQ: state_nx = RD_CAP;
         RD_CAP: begin
            byte_reg_nx = bus.rx_rdata;
            state_nx    = HI;
         end
         HI, LO, SEP, CR, LF: begin
            if (!bus.tx_fifo_full) begin
               tx_wten_nx = 1'b1;
               state_nx   = GAP;
               case (state)
                  HI: begin
                     tx_wdata_nx = hi_ascii;
                     ret_nx      = LO;
                  end
                  LO: begin
                     tx_wdata_nx = lo_ascii;
                     if (byte_cnt == LAST_IDX) begin
                        byte_cnt_nx = '0;
                        ret_nx      = CR;
                     end else begin
                        byte_cnt_nx = byte_cnt + CNT_W'(1);
                        ret_nx      = SEP;
                     end
                  end
                  SEP: begin
                     tx_wdata_nx = ASCII_SP;
                     ret_nx      = IDLE;
                  end
                  CR: begin
                     tx_wdata_nx = ASCII_CR;
                     ret_nx      = LF;
                  end
                  default: begin
                     tx_wdata_nx = ASCII_LF;
                     ret_nx      = IDLE;
                  end
               endcase
            end
         end
         GAP:     state_nx = ret_state;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ret_state    <= IDLE;
         byte_cnt     <= '0;
         idle_cnt     <= '0;
         byte_reg     <= '0;
         bus.rx_rden  <= 1'b0;
         bus.tx_wten  <= 1'b0;
         bus.tx_wdata <= 8'h00;
         dump_err     <= 1'b0;
      end else begin
         ret_state    <= ret_nx;
         byte_cnt     <= byte_cnt_nx;
         idle_cnt     <= idle_cnt_nx;
         byte_reg     <= byte_reg_nx;
         bus.rx_rden  <= rx_rden_nx;
         bus.tx_wten  <= tx_wten_nx;
         bus.tx_wdata <= tx_wdata_nx;
         dump_err     <= dump_err | bus.rx_fifo_overrun | bus.rx_fifo_underrun
                                  | bus.tx_fifo_overrun | bus.tx_fifo_underrun;
      end
   end

endmodule
